// File: rtl/dice_roll_recorder.sv
// rtl/dice_roll_recorder.sv - records one dice result per button release into a show-ahead FIFO
//
// Purpose:
//   Watches the dice roll button and face value. On every button release the
//   face is checked: a valid face (1..6) updates last_throw, bumps the
//   saturating roll counter and is queued in a small FIFO; an invalid face
//   (0 or 7) only raises the sticky bad_throw flag. A downstream consumer
//   drains the FIFO with a valid/ready handshake.
//
// Ports:
//   clk        - rising-edge clock shared with the dice
//   rst        - asynchronous active-low reset
//   button     - roll button, synchronous to clk
//   throw      - face value from the dice (valid 1..6)
//   clr_flags  - synchronous clear of overflow and bad_throw
//   rd_ready   - consumer accepts rd_data this cycle
//   rd_valid   - FIFO holds at least one entry
//   rd_data    - oldest recorded face, 0 when empty
//   level      - number of entries held, 0..DEPTH
//   last_throw - most recent accepted face
//   roll_count - accepted rolls since reset, saturating
//   overflow   - sticky: a valid roll was dropped on a full FIFO
//   bad_throw  - sticky: a release saw face 0 or 7

module dice_roll_recorder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  input  logic             clr_flags,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [2:0]       rd_data,
  output logic [AW:0]      level,
  output logic [2:0]       last_throw,
  output logic [CNT_W-1:0] roll_count,
  output logic             overflow,
  output logic             bad_throw
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic          button_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    mem [DEPTH];

  logic rel;
  logic valid_face;
  logic accept;
  logic bad_event;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // The dice freezes on release, so the face seen on the release edge is final.
  assign rel        = button_q & ~button;
  assign valid_face = (throw != 3'd0) && (throw != 3'd7);
  assign accept     = rel & valid_face;
  assign bad_event  = rel & ~valid_face;

  assign full     = (level == FULL_LEVEL);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign push     = accept & (~full | pop);
  assign drop     = accept & full & ~pop;

  assign rd_data = rd_valid ? mem[rd_ptr] : 3'd0;

  // Storage carries no reset; stale contents are masked by level/rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= throw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      button_q   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      last_throw <= 3'd0;
      roll_count <= '0;
      overflow   <= 1'b0;
      bad_throw  <= 1'b0;
    end else begin
      button_q <= button;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Dropped rolls still count and still update last_throw.
      if (accept) begin
        last_throw <= throw;
        if (roll_count != '1) begin
          roll_count <= roll_count + CNT_W'(1);
        end
      end

      // Set beats clear when both happen in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end

      if (bad_event) begin
        bad_throw <= 1'b1;
      end else if (clr_flags) begin
        bad_throw <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dice_roll_recorder.sv
// tb/tb_dice_roll_recorder.sv - self-checking bench for dice_roll_recorder against a queue model

module tb_dice_roll_recorder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b0;
  logic [2:0] throw = 3'd0;
  logic       clr_flags = 1'b0;
  logic       rd_ready = 1'b0;

  logic        rd_valid, rd_valid_s;
  logic [2:0]  rd_data, rd_data_s;
  logic [AW:0] level, level_s;
  logic [2:0]  last_throw, last_throw_s;
  logic [7:0]  roll_count;
  logic [1:0]  roll_count_s;
  logic        overflow, overflow_s;
  logic        bad_throw, bad_throw_s;

  dice_roll_recorder #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .button(button), .throw(throw),
    .clr_flags(clr_flags), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .last_throw(last_throw), .roll_count(roll_count),
    .overflow(overflow), .bad_throw(bad_throw)
  );

  dice_roll_recorder #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .button(button), .throw(throw),
    .clr_flags(clr_flags), .rd_ready(rd_ready),
    .rd_valid(rd_valid_s), .rd_data(rd_data_s), .level(level_s),
    .last_throw(last_throw_s), .roll_count(roll_count_s),
    .overflow(overflow_s), .bad_throw(bad_throw_s)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of recorded faces plus plain counters/flags.
  int q[$];
  int m_last;
  int m_count;
  bit m_ovf;
  bit m_bad;
  bit m_prev_btn;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last     = 0;
    m_count    = 0;
    m_ovf      = 1'b0;
    m_bad      = 1'b0;
    m_prev_btn = 1'b0;
  endtask

  task automatic check_all();
    int exp_data;
    exp_data = (q.size() != 0) ? q[0] : 0;
    check_eq("rd_valid",   rd_valid,   (q.size() != 0));
    check_eq("rd_data",    rd_data,    exp_data);
    check_eq("level",      level,      q.size());
    check_eq("last_throw", last_throw, m_last);
    check_eq("roll_count", roll_count, (m_count > 255) ? 255 : m_count);
    check_eq("overflow",   overflow,   m_ovf);
    check_eq("bad_throw",  bad_throw,  m_bad);
    check_eq("s_level",    level_s,    q.size());
    check_eq("s_rd_data",  rd_data_s,  exp_data);
    check_eq("s_roll_count", roll_count_s, (m_count > 3) ? 3 : m_count);
  endtask

  // One clock: drive inputs at the falling edge, advance the model, check after the rising edge.
  task automatic cycle(input bit b, input bit [2:0] t, input bit c, input bit r);
    bit rel, pop, push, ov_set, bad_set;
    @(negedge clk);
    button = b; throw = t; clr_flags = c; rd_ready = r;
    rel = m_prev_btn && !b;
    pop = (q.size() != 0) && r;
    push = 1'b0; ov_set = 1'b0; bad_set = 1'b0;
    if (rel) begin
      if (t >= 1 && t <= 6) begin
        m_last = t;
        if (m_count < 1000) m_count++;
        if (q.size() < DEPTH || pop) push = 1'b1;
        else ov_set = 1'b1;
      end else begin
        bad_set = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(int'(t));
    m_ovf = ov_set || (m_ovf && !c);
    m_bad = bad_set || (m_bad && !c);
    m_prev_btn = b;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic roll(input bit [2:0] t, input bit r);
    cycle(1'b1, 3'd2, 1'b0, r);
    cycle(1'b0, t, 1'b0, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; button = 1'b0; clr_flags = 1'b0; rd_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Single roll after a 3-cycle hold.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd1, 1'b0, 1'b0);
    cycle(1'b0, 3'd4, 1'b0, 1'b0);
    check_eq("t1_rd_valid", rd_valid, 1);
    check_eq("t1_rd_data", rd_data, 4);
    check_eq("t1_level", level, 1);
    check_eq("t1_roll_count", roll_count, 1);

    // Nine rolls into an 8-deep FIFO, then drain in order.
    do_reset();
    for (int i = 0; i < 9; i++) roll(3'((i % 6) + 1), 1'b0);
    check_eq("t2_level", level, 8);
    check_eq("t2_overflow", overflow, 1);
    check_eq("t2_roll_count", roll_count, 9);
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_pop_data", rd_data, (i % 6) + 1);
      cycle(1'b0, 3'd0, 1'b0, 1'b1);
    end
    check_eq("t2_empty", rd_valid, 0);

    // Release coinciding with a pop on a full FIFO.
    cycle(1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) roll(3'($urandom_range(1, 6)), 1'b0);
    cycle(1'b1, 3'd1, 1'b0, 1'b0);
    cycle(1'b0, 3'd5, 1'b0, 1'b1);
    check_eq("t3_overflow", overflow, 0);
    check_eq("t3_level", level, 8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);

    // Invalid faces, then clear.
    roll(3'd3, 1'b0);
    roll(3'd0, 1'b0);
    roll(3'd7, 1'b0);
    check_eq("t4_bad_throw", bad_throw, 1);
    check_eq("t4_last_throw", last_throw, 3);
    cycle(1'b0, 3'd0, 1'b1, 1'b1);
    check_eq("t4_cleared", bad_throw, 0);

    // Long hold records nothing; then async reset with three entries queued.
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'(i % 6 + 1), 1'b0, 1'b0);
    check_eq("t5_level_hold", level, 0);
    cycle(1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) roll(3'd6, 1'b0);
    check_eq("t5_level3", level, 3);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) roll(3'(i + 1), 1'b0);
    check_eq("t6_small_count", roll_count_s, 3);
    check_eq("t6_small_level", level_s, 5);

    // Random traffic: a low-ready phase to hit full, then a high-ready phase.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit b, c, r;
      int tv;
      b  = ($urandom_range(0, 2) != 0) ? !m_prev_btn : m_prev_btn;
      tv = $urandom_range(0, 9);
      if (tv > 7) tv = $urandom_range(1, 6);
      c  = ($urandom_range(0, 15) == 0);
      r  = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(b, 3'(tv), c, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
